neuron_sequencer: RTL and testbench

- Control and sequencing stage directly upstream of one logical_unit neuron accumulator.
- Accepts an input vector one word per handshake and reads the matching weight from a combinational-read weight memory.
- Drives the accumulator's mem/data/add_bias/sum_en/reset controls, then appends the bias term.
- Captures the saturated result and presents it downstream with a valid/ready handshake.

---
 rtl/neuron_sequencer.sv | 140 ++++++++++++++
 tb/tb_neuron_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sequencer.sv
// Sequencer feeding one neuron accumulator: walks the weights, then the bias, and hands the result downstream.
// Optional NEURON_RELU_EN clamps negative results to zero when the result is captured.
module neuron_sequencer #(
    parameter int WORD_SIZE  = 16,
    parameter int INPUT_SIZE = 8,
    parameter int LU_LATENCY = 1,
    parameter int ADDR_W     = $clog2(INPUT_SIZE + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic signed [WORD_SIZE-1:0] data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic        [ADDR_W-1:0]    mem_addr_o,
    input  logic signed [WORD_SIZE-1:0] mem_data_i,
    output logic signed [WORD_SIZE-1:0] lu_mem_o,
    output logic signed [WORD_SIZE-1:0] lu_data_o,
    output logic                        lu_add_bias_o,
    output logic                        lu_sum_en_o,
    output logic                        lu_reset_o,
    input  logic signed [WORD_SIZE-1:0] lu_result_i,
    output logic signed [WORD_SIZE-1:0] data_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam int WAIT_W = (LU_LATENCY > 1) ? $clog2(LU_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE - 1);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(INPUT_SIZE);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LU_LATENCY - 1);

    typedef enum logic [2:0] {
        CLEAR,
        ACCUM,
        BIAS,
        WAIT,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [ADDR_W-1:0]           count;
    logic [ADDR_W-1:0]           count_next;
    logic [WAIT_W-1:0]           wait_cnt;
    logic [WAIT_W-1:0]           wait_cnt_next;
    logic signed [WORD_SIZE-1:0] result_p0;
    logic signed [WORD_SIZE-1:0] result_p0_next;
    logic                        vld_p0;
    logic                        vld_p0_next;

    function automatic logic signed [WORD_SIZE-1:0] activate(input logic signed [WORD_SIZE-1:0] x);
`ifdef NEURON_RELU_EN
        return x[WORD_SIZE-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // The accumulator sees the weight and data words untouched; only sum_en decides whether it adds.
    assign lu_mem_o  = mem_data_i;
    assign lu_data_o = data_i;
    assign data_o    = result_p0;
    assign valid_o   = vld_p0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= CLEAR;
            count     <= '0;
            wait_cnt  <= '0;
            result_p0 <= '0;
            vld_p0    <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            wait_cnt  <= wait_cnt_next;
            result_p0 <= result_p0_next;
            vld_p0    <= vld_p0_next;
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        wait_cnt_next  = wait_cnt;
        result_p0_next = result_p0;
        vld_p0_next    = vld_p0;
        ready_o        = 1'b0;
        mem_addr_o     = '0;
        lu_sum_en_o    = 1'b0;
        lu_add_bias_o  = 1'b0;
        lu_reset_o     = 1'b0;

        case (state)
            CLEAR: begin
                lu_reset_o = 1'b1;
                count_next = '0;
                state_next = ACCUM;
            end
            ACCUM: begin
                ready_o     = 1'b1;
                mem_addr_o  = count;
                lu_sum_en_o = valid_i;
                if (valid_i) begin
                    if (count == LAST_ADDR) begin
                        count_next = '0;
                        state_next = BIAS;
                    end else begin
                        count_next = count + ADDR_W'(1);
                    end
                end
            end
            BIAS: begin
                mem_addr_o    = BIAS_ADDR;
                lu_sum_en_o   = 1'b1;
                lu_add_bias_o = 1'b1;
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            // Capture stage: the accumulator output is only trusted LU_LATENCY cycles after the bias add.
            WAIT: begin
                wait_cnt_next = wait_cnt + WAIT_W'(1);
                if (wait_cnt == LAST_WAIT) begin
                    result_p0_next = activate(lu_result_i);
                    vld_p0_next    = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    vld_p0_next = 1'b0;
                    state_next  = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer with a Q4.12 accumulator model and a vector-level reference.
module tb_neuron_sequencer;

    localparam int WS  = 16;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int AW  = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic [WS-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [AW-1:0] mem_addr_o;
    logic [WS-1:0] mem_data_i;
    logic [WS-1:0] lu_mem_o;
    logic [WS-1:0] lu_data_o;
    logic          lu_add_bias_o;
    logic          lu_sum_en_o;
    logic          lu_reset_o;
    logic [WS-1:0] lu_result_i;
    logic [WS-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    logic [WS-1:0] wmem [0:7];
    logic [WS-1:0] xin  [0:N-1];
    logic [WS-1:0] acc;

    int n_cmp = 0;
    int n_err = 0;

    neuron_sequencer #(
        .WORD_SIZE (WS),
        .INPUT_SIZE(N),
        .LU_LATENCY(LAT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .lu_mem_o     (lu_mem_o),
        .lu_data_o    (lu_data_o),
        .lu_add_bias_o(lu_add_bias_o),
        .lu_sum_en_o  (lu_sum_en_o),
        .lu_reset_o   (lu_reset_o),
        .lu_result_i  (lu_result_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    assign mem_data_i  = wmem[mem_addr_o];
    assign lu_result_i = acc;

    function automatic logic [WS-1:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic int mulq(input logic [WS-1:0] a, input logic [WS-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return (ia * ib) >>> 12;
    endfunction

    function automatic logic [WS-1:0] relu_ref(input logic [WS-1:0] x);
`ifdef NEURON_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    // Whole-vector expectation: saturating dot product in Q4.12, then the bias, then the activation.
    function automatic logic [WS-1:0] ref_neuron();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s = $signed(sat16(s + mulq(wmem[i], xin[i])));
        s = $signed(sat16(s + int'($signed(wmem[N]))));
        return relu_ref(s[15:0]);
    endfunction

    // Accumulator model standing in for the downstream logical_unit (one cycle of latency).
    always @(posedge clk) begin
        if (lu_reset_o)
            acc <= 16'h0000;
        else if (lu_sum_en_o)
            acc <= lu_add_bias_o ? sat16(int'($signed(acc)) + int'($signed(lu_mem_o)))
                                 : sat16(int'($signed(acc)) + mulq(lu_mem_o, lu_data_o));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_vector(input int bubble_at, input int bubbles, input int bp,
                              input bit junk, input bit reset_in_done, input logic [WS-1:0] exp_res);
        int n;
        valid_i = 1'b0;
        ready_i = 1'b0;
        n = 0;
        while (!ready_o && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check("accum_entry", ready_o, 1);
        for (int i = 0; i < N; i++) begin
            if (i == bubble_at) begin
                for (int b = 0; b < bubbles; b++) begin
                    valid_i = 1'b0;
                    data_i  = 16'($urandom);
                    #1;
                    check("bubble_sum_en", lu_sum_en_o, 0);
                    check("bubble_addr", mem_addr_o, i);
                    @(negedge clk);
                end
            end
            valid_i = 1'b1;
            data_i  = xin[i];
            #1;
            check("word_ready", ready_o, 1);
            check("word_addr", mem_addr_o, i);
            check("word_sum_en", lu_sum_en_o, 1);
            check("word_add_bias", lu_add_bias_o, 0);
            check("word_lu_data", lu_data_o, xin[i]);
            check("word_lu_mem", lu_mem_o, wmem[i]);
            @(negedge clk);
        end
        valid_i = junk;
        data_i  = 16'($urandom);
        #1;
        check("bias_addr", mem_addr_o, N);
        check("bias_add_bias", lu_add_bias_o, 1);
        check("bias_sum_en", lu_sum_en_o, 1);
        check("bias_ready", ready_o, 0);
        check("bias_lu_mem", lu_mem_o, wmem[N]);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
            if (!valid_o) begin
                check("wait_sum_en", lu_sum_en_o, 0);
                check("wait_ready", ready_o, 0);
            end
        end while (!valid_o && n < 10);
        check("latency", n, LAT + 1);
        check("result", data_o, exp_res);
        if (reset_in_done) begin
            #1;
            reset_i = 1'b1;
            #1;
            check("rst_done_valid", valid_o, 0);
            check("rst_done_data", data_o, 0);
            check("rst_done_lu_reset", lu_reset_o, 1);
            @(negedge clk);
            reset_i = 1'b0;
            valid_i = 1'b0;
        end else begin
            for (int b = 0; b < bp; b++) begin
                check("bp_valid", valid_o, 1);
                check("bp_data", data_o, exp_res);
                check("bp_ready", ready_o, 0);
                check("bp_sum_en", lu_sum_en_o, 0);
                check("bp_lu_reset", lu_reset_o, 0);
                @(negedge clk); #1;
            end
            ready_i = 1'b1;
            #1;
            check("hs_valid", valid_o, 1);
            check("hs_data", data_o, exp_res);
            @(negedge clk);
            ready_i = 1'b0;
            #1;
            check("clear_lu_reset", lu_reset_o, 1);
            check("clear_valid", valid_o, 0);
            check("clear_ready", ready_o, 0);
            check("clear_sum_en", lu_sum_en_o, 0);
            valid_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        for (int i = 0; i < N; i++) wmem[i] = 16'h1000;
        wmem[N] = 16'h0800;
        for (int i = N + 1; i < 8; i++) wmem[i] = 16'h0000;

        repeat (3) @(negedge clk);
        valid_i = 1'b1;
        #1;
        check("rst_lu_reset", lu_reset_o, 1);
        check("rst_ready", ready_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_sum_en", lu_sum_en_o, 0);
        check("rst_add_bias", lu_add_bias_o, 0);
        valid_i = 1'b0;
        reset_i = 1'b0;
        #1;
        check("clear_after_rst_lu_reset", lu_reset_o, 1);
        check("clear_after_rst_ready", ready_o, 0);
        @(negedge clk); #1;
        check("idle_ready", ready_o, 1);
        check("idle_lu_reset", lu_reset_o, 0);
        check("idle_valid", valid_o, 0);
        check("idle_data", data_o, 0);

        // Directed Q4.12 vectors: 1.0, 2.0, 0.0, -1.0 with unit weights plus 0.5 bias.
        xin[0] = 16'h1000; xin[1] = 16'h2000; xin[2] = 16'h0000; xin[3] = 16'hF000;
        run_vector(-1, 0, 0, 1'b0, 1'b0, 16'h2800);
        run_vector(2, 3, 0, 1'b0, 1'b0, 16'h2800);
        run_vector(-1, 0, 5, 1'b1, 1'b0, 16'h2800);

        xin[0] = 16'hF000; xin[1] = 16'h0000; xin[2] = 16'h0000; xin[3] = 16'h0000;
`ifdef NEURON_RELU_EN
        run_vector(-1, 0, 0, 1'b0, 1'b0, 16'h0000);
`else
        run_vector(-1, 0, 0, 1'b0, 1'b0, 16'hF800);
`endif

        // Reset after two accepted words; the fresh vector must not see them.
        xin[0] = 16'h1000; xin[1] = 16'h2000; xin[2] = 16'h0000; xin[3] = 16'hF000;
        n = 0;
        while (!ready_o && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_entry", ready_o, 1);
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            data_i  = xin[i];
            @(negedge clk);
        end
        valid_i = 1'b1;
        data_i  = 16'h7FFF;
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_ready", ready_o, 0);
        check("mid_rst_lu_reset", lu_reset_o, 1);
        check("mid_rst_sum_en", lu_sum_en_o, 0);
        check("mid_rst_addr", mem_addr_o, 0);
        check("mid_rst_valid", valid_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < N; i++) xin[i] = 16'h1000;
        run_vector(-1, 0, 0, 1'b0, 1'b0, 16'h4800);

        run_vector(-1, 0, 0, 1'b0, 1'b1, 16'h4800);
        run_vector(1, 2, 1, 1'b1, 1'b0, 16'h4800);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i <= N; i++) begin
                if (r % 2 == 0) wmem[i] = 16'(int'($urandom_range(0, 8191)) - 4096);
                else            wmem[i] = 16'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) xin[i] = 16'(int'($urandom_range(0, 16383)) - 8192);
                else            xin[i] = 16'($urandom);
            end
            run_vector(int'($urandom_range(0, N)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, ref_neuron());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
